// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
//   Runtime-selectable character length (5..DATA_BITS_MAX), parity
//   (none/even/odd), one or two stop bits. Each bit is decided by a
//   3-sample majority vote around mid-bit. Parity, framing and break
//   conditions are reported alongside each received character.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  receiver enable; low drops any frame in progress
//   clk_divider_valid   load clk_divider, restart tick counter, abort frame
//   clk_divider         sample tick period = clk_divider+1 clocks
//   data_bits           character length, clamped to [5,DATA_BITS_MAX]
//   parity_mode         00 none, 01 even, 10 odd, 11 none
//   stop_bits           0: one stop bit, 1: two
//   sin                 serial input, idle high
//   receiver_busy       high whenever the FSM is not idle
//   rx_data_valid       one-clock pulse per completed character
//   rx_data             received character, unused MSBs zero
//   rx_parity_error     parity mismatch, valid with rx_data_valid
//   rx_frame_error      a stop bit sampled low, valid with rx_data_valid
//   rx_break            break character, valid with rx_data_valid
module uart_rx_cfg #(
  parameter int DATA_BITS_MAX = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_W         = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clk_divider_valid,
  input  logic [DIV_W-1:0]         clk_divider,
  input  logic [3:0]               data_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     stop_bits,
  input  logic                     sin,
  output logic                     receiver_busy,
  output logic                     rx_data_valid,
  output logic [DATA_BITS_MAX-1:0] rx_data,
  output logic                     rx_parity_error,
  output logic                     rx_frame_error,
  output logic                     rx_break
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_VOTE0 = SW'(M - 1);
  localparam logic [SW-1:0] S_VOTE1 = SW'(M);
  localparam logic [SW-1:0] S_VOTE2 = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    NB_MIN  = 4'd5;
  localparam logic [3:0]    NB_MAX  = 4'(DATA_BITS_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]         div_q, tcnt_q;
  logic                     tick;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sin_s, sin_prev_q, fall;
  logic [SW-1:0]            s_q;
  logic                     v0_q, v1_q, maj;
  logic                     at_mid, at_end;
  logic [3:0]               nbits_in, nbits_q, bit_cnt_q;
  logic [1:0]               pm_q;
  logic                     two_stop_q, par_en_q, par_q, stop0_q, fe_acc_q, stop_cnt_q;
  logic [DATA_BITS_MAX-1:0] data_q;
  logic                     last_data, last_stop, done;
  logic                     first_stop, brk_now, fe_now, pe_now;

  // Sample tick generator
  assign tick = (tcnt_q == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tcnt_q <= '0;
    end else if (clk_divider_valid) begin
      div_q  <= clk_divider;
      tcnt_q <= '0;
    end else if (tick) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Input synchroniser and edge detect
  assign sin_s = sync_q[SYNC_STAGES-1];
  assign fall  = sin_prev_q & ~sin_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      sin_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sin};
      sin_prev_q <= sin_s;
    end
  end

  always_comb begin
    nbits_in = data_bits;
    if (data_bits < NB_MIN)      nbits_in = NB_MIN;
    else if (data_bits > NB_MAX) nbits_in = NB_MAX;
  end

  assign at_mid    = tick && (s_q == S_VOTE2);
  assign at_end    = tick && (s_q == S_LAST);
  assign maj       = (v0_q & v1_q) | (v0_q & sin_s) | (v1_q & sin_s);
  assign last_data = (bit_cnt_q == nbits_q - 1'b1);
  assign last_stop = (stop_cnt_q == two_stop_q);
  assign done      = (state_q == STOP) && at_mid && last_stop;

  // Completion flags; the final stop sample is still in flight as maj
  assign first_stop = stop_cnt_q ? stop0_q : maj;
  assign fe_now     = fe_acc_q | ~maj;
  assign pe_now     = par_en_q && ((^data_q ^ par_q) != (pm_q == 2'b10));
  assign brk_now    = (data_q == '0) && !(par_en_q && par_q) && !first_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en || clk_divider_valid) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (fall) state_d = START;
        START:    if (at_mid && maj) state_d = IDLE;
                  else if (at_end) state_d = DATA;
        DATA:     if (at_end && last_data) state_d = par_en_q ? PARITY : STOP;
        PARITY:   if (at_end) state_d = STOP;
        STOP:     if (done) state_d = brk_now ? BRK_WAIT : IDLE;
        BRK_WAIT: if (sin_s) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign receiver_busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q             <= '0;
      v0_q            <= 1'b1;
      v1_q            <= 1'b1;
      nbits_q         <= NB_MIN;
      bit_cnt_q       <= '0;
      pm_q            <= '0;
      two_stop_q      <= 1'b0;
      par_en_q        <= 1'b0;
      par_q           <= 1'b0;
      stop0_q         <= 1'b1;
      stop_cnt_q      <= 1'b0;
      fe_acc_q        <= 1'b0;
      data_q          <= '0;
      rx_data_valid   <= 1'b0;
      rx_data         <= '0;
      rx_parity_error <= 1'b0;
      rx_frame_error  <= 1'b0;
      rx_break        <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;

      if (state_q == IDLE) s_q <= '0;
      else if (at_end)     s_q <= '0;
      else if (tick)       s_q <= s_q + 1'b1;

      if (tick && s_q == S_VOTE0) v0_q <= sin_s;
      if (tick && s_q == S_VOTE1) v1_q <= sin_s;

      if (state_q == IDLE && state_d == START) begin
        nbits_q    <= nbits_in;
        pm_q       <= parity_mode;
        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        two_stop_q <= stop_bits;
        data_q     <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        fe_acc_q   <= 1'b0;
      end

      case (state_q)
        DATA: begin
          if (at_mid) data_q[bit_cnt_q] <= maj;
          if (at_end && !last_data) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        PARITY: if (at_mid) par_q <= maj;
        STOP: begin
          if (at_mid) begin
            if (!stop_cnt_q) stop0_q <= maj;
            fe_acc_q <= fe_now;
          end
          if (at_end) stop_cnt_q <= 1'b1;
        end
        default: ;
      endcase

      // A divider load or disable in the completion cycle suppresses the pulse
      if (done && en && !clk_divider_valid) begin
        rx_data_valid   <= 1'b1;
        rx_data         <= data_q;
        rx_parity_error <= pe_now;
        rx_frame_error  <= fe_now;
        rx_break        <= brk_now;
      end
    end
  end

endmodule
